// File: rtl/turn_flasher_ctrl_pkg.sv
// Shared types and default constants for the turn/hazard/ESS flasher.
// Used by the top level, the flash timer and the bench.
package flasher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEFT   = 3'd1,
        ST_RIGHT  = 3'd2,
        ST_HAZARD = 3'd3,
        ST_ESS    = 3'd4
    } flasher_state_t;

    // ~340 ms and 100 ms half-periods at 50 MHz
    localparam int TURN_HALF_CYC_DEF = 17_000_000;
    localparam int ESS_HALF_CYC_DEF  = 5_000_000;
    localparam int ESS_MIN_SPEED_DEF = 50;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/turn_flasher_ctrl_if.sv
// Switch/vehicle inputs and lamp/sound outputs of the flasher controller.
// master: switch/vehicle-dynamics side; slave: the controller itself.
interface turn_flasher_ctrl_if;

    logic       sw_left;
    logic       sw_right;
    logic       sw_hazard;
    logic       hard_brake;
    logic       accel_active;
    logic [7:0] speed;
    logic       left_led;
    logic       right_led;
    logic       turn_signal_on;
    logic       ess_active;

    modport master (
        output sw_left, sw_right, sw_hazard, hard_brake, accel_active, speed,
        input  left_led, right_led, turn_signal_on, ess_active
    );

    modport slave (
        input  sw_left, sw_right, sw_hazard, hard_brake, accel_active, speed,
        output left_led, right_led, turn_signal_on, ess_active
    );

endinterface

// File: rtl/turn_flasher_ctrl_flash_timer.sv
// Blink phase generator: counts 0..half_cyc-1 and toggles the phase at wrap.
// o_phase_nxt exposes the value loaded on the next edge so the caller can
// register lamp drives in step with the phase.
module flash_timer #(
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_restart,
    input  logic           i_run,
    input  logic [CNT_W:0] i_half_cyc,
    output logic           o_phase,
    output logic           o_phase_nxt
);

    localparam logic [CNT_W:0]   HALF_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_phase;
    logic             w_phase_nxt;
    logic             w_last;

    assign w_last = ({1'b0, r_cnt} == (i_half_cyc - HALF_ONE));

    // Restart forces ON at count 0; running wraps at half_cyc-1; idle holds 0.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        if (i_restart) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b1;
        end else if (i_run) begin
            if (w_last) begin
                w_cnt_nxt   = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_cnt_nxt = r_cnt + CNT_ONE;
            end
        end else begin
            w_cnt_nxt = '0;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    assign o_phase     = r_phase;
    assign o_phase_nxt = w_phase_nxt;

endmodule

// File: rtl/turn_flasher_ctrl.sv
// Turn-signal / hazard / emergency-stop-signal lamp controller.
// Optional feature macro: TURN_FLASHER_ESS_EN (ESS latch and ESS state).
//
//   state  | meaning
//   IDLE   | no indicator requested, lamps off, timer held at 0
//   LEFT   | left lamp blinks at turn rate
//   RIGHT  | right lamp blinks at turn rate
//   HAZARD | both lamps blink at turn rate (hazard switch or left+right)
//   ESS    | both lamps blink at ESS rate after a hard brake at speed
module turn_flasher_ctrl
    import flasher_pkg::*;
#(
    parameter int TURN_HALF_CYC = TURN_HALF_CYC_DEF,
    parameter int ESS_HALF_CYC  = ESS_HALF_CYC_DEF,
    parameter int ESS_MIN_SPEED = ESS_MIN_SPEED_DEF
) (
    input  logic                clk,
    input  logic                rst,
    turn_flasher_ctrl_if.slave  fl
);

`ifdef TURN_FLASHER_ESS_EN
    localparam int HALF_MAX = max_int(TURN_HALF_CYC, ESS_HALF_CYC);
`else
    localparam int HALF_MAX = TURN_HALF_CYC;
`endif
    localparam int CNT_W = (HALF_MAX > 2) ? $clog2(HALF_MAX) : 1;
    localparam int HW    = CNT_W + 1;

    localparam logic [CNT_W:0] TURN_H = HW'(TURN_HALF_CYC);

    logic [1:0]     r_sync_l;
    logic [1:0]     r_sync_r;
    logic [1:0]     r_sync_h;
    logic           w_left;
    logic           w_right;
    logic           w_hazard;
    logic           w_ess;
    flasher_state_t r_state;
    flasher_state_t w_state_nxt;
    logic           w_restart;
    logic           w_run;
    logic [CNT_W:0] w_half;
    logic           w_phase;
    logic           w_phase_nxt;
    logic           w_left_nxt;
    logic           w_right_nxt;
    logic           r_left_led;
    logic           r_right_led;
    logic           r_turn_on;
    logic           r_ess_active;

    // Two-flop synchronizers for the asynchronous switch levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_l <= '0;
            r_sync_r <= '0;
            r_sync_h <= '0;
        end else begin
            r_sync_l <= {r_sync_l[0], fl.sw_left};
            r_sync_r <= {r_sync_r[0], fl.sw_right};
            r_sync_h <= {r_sync_h[0], fl.sw_hazard};
        end
    end

    assign w_left   = r_sync_l[1];
    assign w_right  = r_sync_r[1];
    assign w_hazard = r_sync_h[1];

`ifdef TURN_FLASHER_ESS_EN
    localparam logic [CNT_W:0] ESS_H   = HW'(ESS_HALF_CYC);
    localparam logic [7:0]     MIN_SPD = 8'(ESS_MIN_SPEED);

    logic r_ess_latch;

    // ESS latch: arming on hard brake at speed takes precedence over clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ess_latch <= 1'b0;
        end else if (fl.hard_brake && (fl.speed >= MIN_SPD)) begin
            r_ess_latch <= 1'b1;
        end else if (fl.accel_active && !fl.hard_brake) begin
            r_ess_latch <= 1'b0;
        end
    end

    assign w_ess  = r_ess_latch;
    assign w_half = (r_state == ST_ESS) ? ESS_H : TURN_H;
`else
    logic w_unused_ess;

    assign w_unused_ess = ^{fl.hard_brake, fl.accel_active, fl.speed};
    assign w_ess        = 1'b0;
    assign w_half       = TURN_H;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection by priority ESS > HAZARD > LEFT/RIGHT > IDLE.
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_ess) begin
            w_state_nxt = ST_ESS;
        end else if (w_hazard || (w_left && w_right)) begin
            w_state_nxt = ST_HAZARD;
        end else if (w_left) begin
            w_state_nxt = ST_LEFT;
        end else if (w_right) begin
            w_state_nxt = ST_RIGHT;
        end
    end

    // Any mode change restarts the blink at ON so a new mode never inherits
    // a partially elapsed half-period.
    assign w_restart = (w_state_nxt != r_state);
    assign w_run     = (r_state != ST_IDLE);

    flash_timer #(
        .CNT_W (CNT_W)
    ) u_flash_timer (
        .clk         (clk),
        .rst         (rst),
        .i_restart   (w_restart),
        .i_run       (w_run),
        .i_half_cyc  (w_half),
        .o_phase     (w_phase),
        .o_phase_nxt (w_phase_nxt)
    );

    // Lamp decode from the state and phase being loaded on the next edge.
    always_comb begin
        w_left_nxt  = 1'b0;
        w_right_nxt = 1'b0;
        case (w_state_nxt)
            ST_LEFT:   w_left_nxt  = w_phase_nxt;
            ST_RIGHT:  w_right_nxt = w_phase_nxt;
            ST_HAZARD,
            ST_ESS: begin
                w_left_nxt  = w_phase_nxt;
                w_right_nxt = w_phase_nxt;
            end
            default: ;
        endcase
    end

    // Output registers keep the lamp and sound-unit levels glitch free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_left_led   <= 1'b0;
            r_right_led  <= 1'b0;
            r_turn_on    <= 1'b0;
            r_ess_active <= 1'b0;
        end else begin
            r_left_led   <= w_left_nxt;
            r_right_led  <= w_right_nxt;
            r_turn_on    <= w_left_nxt | w_right_nxt;
            r_ess_active <= (w_state_nxt == ST_ESS);
        end
    end

    assign fl.left_led       = r_left_led;
    assign fl.right_led      = r_right_led;
    assign fl.turn_signal_on = r_turn_on;
    assign fl.ess_active     = r_ess_active;

endmodule

// File: tb/tb_turn_flasher_ctrl.sv
// Directed bench for turn_flasher_ctrl with short half-periods (10 / 4).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_turn_flasher_ctrl;
    import flasher_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    turn_flasher_ctrl_if fl ();

    turn_flasher_ctrl #(
        .TURN_HALF_CYC (10),
        .ESS_HALF_CYC  (4),
        .ESS_MIN_SPEED (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_lamps(input string tag, input logic l, input logic r, input logic e);
        chk({tag, "_left"},  32'(fl.left_led),       32'(l));
        chk({tag, "_right"}, 32'(fl.right_led),      32'(r));
        chk({tag, "_tso"},   32'(fl.turn_signal_on), 32'(l | r));
        chk({tag, "_ess"},   32'(fl.ess_active),     32'(e));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        fl.sw_left      = 1'b0;
        fl.sw_right     = 1'b0;
        fl.sw_hazard    = 1'b0;
        fl.hard_brake   = 1'b0;
        fl.accel_active = 1'b0;
        fl.speed        = 8'd0;

        // Reset
        tick(2);
        chk_lamps("in_rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(20);
        chk_lamps("rst_idle", 1'b0, 1'b0, 1'b0);
        chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

        // Left blink: on after 3rd edge, toggles every 10 edges
        fl.sw_left = 1'b1;
        tick(2);
        chk_lamps("left_e2", 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_lamps("left_e3", 1'b1, 1'b0, 1'b0);
        tick(9);
        chk_lamps("left_on9", 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_lamps("left_off10", 1'b0, 1'b0, 1'b0);
        tick(9);
        chk_lamps("left_off19", 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_lamps("left_on20", 1'b1, 1'b0, 1'b0);
        tick(5);
        chk_lamps("left_on25", 1'b1, 1'b0, 1'b0);

        // Hazard overrides left, phase restarts at ON
        fl.sw_hazard = 1'b1;
        tick(2);
        chk_lamps("haz_e2", 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_lamps("haz_e3", 1'b1, 1'b1, 1'b0);
        chk("haz_state", 32'(dut.r_state), 32'(ST_HAZARD));
        tick(2);
        chk_lamps("haz_h2", 1'b1, 1'b1, 1'b0);
        tick(7);
        chk_lamps("haz_h9", 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_lamps("haz_h10", 1'b0, 1'b0, 1'b0);

        // Back to left, restarted at ON
        fl.sw_hazard = 1'b0;
        tick(2);
        chk_lamps("back_e2", 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_lamps("back_e3", 1'b1, 1'b0, 1'b0);
        tick(10);
        chk_lamps("back_l10", 1'b0, 1'b0, 1'b0);
        tick(10);
        chk_lamps("back_l20", 1'b1, 1'b0, 1'b0);

        // Left to right during ON: other lamp on, click level stays high
        fl.sw_left  = 1'b0;
        fl.sw_right = 1'b1;
        tick(2);
        chk_lamps("l2r_e2", 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_lamps("l2r_e3", 1'b0, 1'b1, 1'b0);
        tick(10);
        chk_lamps("right_r10", 1'b0, 1'b0, 1'b0);

        // Left and right together behave as hazard
        fl.sw_left = 1'b1;
        tick(3);
        chk_lamps("lr_haz", 1'b1, 1'b1, 1'b0);
        chk("lr_state", 32'(dut.r_state), 32'(ST_HAZARD));
        tick(10);
        chk_lamps("lr_haz10", 1'b0, 1'b0, 1'b0);

        fl.sw_left  = 1'b0;
        fl.sw_right = 1'b0;
        tick(3);
        chk_lamps("to_idle", 1'b0, 1'b0, 1'b0);
        chk("idle_state", 32'(dut.r_state), 32'(ST_IDLE));

`ifdef TURN_FLASHER_ESS_EN
        // Hard brake below minimum speed: no ESS
        fl.speed      = 8'd40;
        fl.hard_brake = 1'b1;
        tick(1);
        fl.hard_brake = 1'b0;
        tick(3);
        chk_lamps("ess_slow", 1'b0, 1'b0, 1'b0);

        // Hard brake at 60 km/h for one cycle arms ESS
        fl.speed      = 8'd60;
        fl.hard_brake = 1'b1;
        tick(1);
        fl.hard_brake = 1'b0;
        chk_lamps("ess_a1", 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_lamps("ess_a2", 1'b1, 1'b1, 1'b1);
        tick(3);
        chk_lamps("ess_a5", 1'b1, 1'b1, 1'b1);
        tick(1);
        chk_lamps("ess_a6", 1'b0, 1'b0, 1'b1);
        tick(4);
        chk_lamps("ess_a10", 1'b1, 1'b1, 1'b1);

        // ESS dominates a left switch
        fl.sw_left = 1'b1;
        tick(3);
        chk_lamps("ess_over_left", 1'b1, 1'b1, 1'b1);

        // Accelerator without brake clears ESS, left resumes at ON
        fl.accel_active = 1'b1;
        tick(1);
        fl.accel_active = 1'b0;
        chk_lamps("ess_clr_b1", 1'b0, 1'b0, 1'b1);
        tick(1);
        chk_lamps("ess_clr_b2", 1'b1, 1'b0, 1'b0);
        chk("clr_state", 32'(dut.r_state), 32'(ST_LEFT));

        // Set and clear in the same cycle: set wins
        fl.hard_brake   = 1'b1;
        fl.accel_active = 1'b1;
        tick(1);
        fl.hard_brake = 1'b0;
        chk("ess_both_b1", 32'(fl.ess_active), 32'(0));
        tick(1);
        chk_lamps("ess_both_b2", 1'b1, 1'b1, 1'b1);
        // accel still high with brake released clears it again
        tick(1);
        fl.accel_active = 1'b0;
        chk_lamps("ess_both_clr", 1'b1, 1'b0, 1'b0);
        fl.sw_left = 1'b0;
        fl.speed   = 8'd0;
        tick(3);
        chk_lamps("ess_idle", 1'b0, 1'b0, 1'b0);
`else
        // Without ESS support a hard brake at speed has no effect
        fl.speed      = 8'd100;
        fl.hard_brake = 1'b1;
        tick(3);
        chk_lamps("noess_brake3", 1'b0, 1'b0, 1'b0);
        tick(5);
        fl.hard_brake = 1'b0;
        chk_lamps("noess_brake8", 1'b0, 1'b0, 1'b0);
        chk("noess_state", 32'(dut.r_state), 32'(ST_IDLE));
        fl.speed = 8'd0;
`endif

        // Reset during an ON phase clears outputs without waiting for an edge
        fl.sw_left = 1'b1;
        tick(3);
        chk_lamps("pre_rst", 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_lamps("async_rst", 1'b0, 1'b0, 1'b0);
        tick(1);
        rst        = 1'b0;
        fl.sw_left = 1'b0;
        tick(3);
        chk_lamps("post_rst", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
